bp_tournament: RTL and testbench

Parametrised tournament branch predictor. It combines a gshare global predictor and a per-PC local-history predictor through a saturating chooser table. The global history is updated speculatively at decode and restored from a snapshot on a mispredict. Prediction is issued in F; training happens in M from a metadata word that the pipeline carries alongside the branch. The block sits beside the fetch PC mux and replaces the fixed-size predictor.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_sat_table.sv | 42 ++++
 rtl/bp_tournament.sv | 140 ++++++++++++++
 tb/tb_bp_tournament.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the tournament branch predictor.
package bp_pkg;

    localparam int unsigned PHT_DEPTH_DEF = 7;
    localparam int unsigned BHT_DEPTH_DEF = 3;
    localparam int unsigned GHR_WIDTH_DEF = 4;
    localparam int unsigned CTR_WIDTH_DEF = 2;

    // Metadata layout, LSB first: p_local, p_global, bhr_snap, ghr_snap.
    localparam int unsigned META_PL_OFF  = 0;
    localparam int unsigned META_PG_OFF  = 1;
    localparam int unsigned META_BHR_OFF = 2;

    function automatic int unsigned meta_ghr_off(input int unsigned bhr_w);
        return META_BHR_OFF + bhr_w;
    endfunction

    // Weakly not-taken / weakly global: just below the midpoint.
    function automatic logic [31:0] ctr_init(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_table.sv
// Array of saturating counters: combinational read port plus one up/down
// read-modify-write port that also exposes the entry it is about to update.
module bp_sat_table
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH     = PHT_DEPTH_DEF,
    parameter int unsigned CTR_WIDTH = CTR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DEPTH-1:0]     rd_idx,
    output logic [CTR_WIDTH-1:0] rd_ctr,
    input  logic                 we,
    input  logic [DEPTH-1:0]     wr_idx,
    input  logic                 wr_up,
    output logic [CTR_WIDTH-1:0] wr_cur
);

    localparam int unsigned N = 1 << DEPTH;
    localparam logic [CTR_WIDTH-1:0] INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] ctr_q [N];
    logic [CTR_WIDTH-1:0] ctr_d;

    always_comb begin
        rd_ctr = ctr_q[rd_idx];
        wr_cur = ctr_q[wr_idx];
        ctr_d  = wr_up ? CTR_WIDTH'(sat_inc(32'(wr_cur), CTR_WIDTH))
                       : CTR_WIDTH'(sat_dec(32'(wr_cur), CTR_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                ctr_q[i] <= INIT;
            end
        end else if (we) begin
            ctr_q[wr_idx] <= ctr_d;
        end
    end

endmodule

// File: rtl/bp_tournament.sv
// Tournament predictor: gshare and per-PC local history arbitrated by a
// chooser, with speculative GHR update at D and snapshot recovery at M.
module bp_tournament
    import bp_pkg::*;
#(
    parameter  int unsigned PHT_DEPTH = PHT_DEPTH_DEF,
    parameter  int unsigned BHT_DEPTH = BHT_DEPTH_DEF,
    parameter  int unsigned GHR_WIDTH = GHR_WIDTH_DEF,
    parameter  int unsigned CTR_WIDTH = CTR_WIDTH_DEF,
    localparam int unsigned BHR_WIDTH = PHT_DEPTH - BHT_DEPTH,
    localparam int unsigned META_W    = GHR_WIDTH + BHR_WIDTH + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pcF,
    output logic              takenF,
    output logic [META_W-1:0] metaF,
    input  logic              branchD,
    input  logic              takenD,
    input  logic              stall,
    input  logic              branchM,
    input  logic              actualM,
    input  logic [31:0]       pcM,
    input  logic [META_W-1:0] metaM,
    output logic              mispredM
);

    localparam int unsigned BHT_N   = 1 << BHT_DEPTH;
    localparam int unsigned GHR_OFF = meta_ghr_off(BHR_WIDTH);
    localparam int unsigned MSB     = CTR_WIDTH - 1;

    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [BHR_WIDTH-1:0] bht_q [BHT_N];
    logic [BHR_WIDTH-1:0] bht_d;

    logic [PHT_DEPTH-1:0] gidx_f, lidx_f, gidx_m, lidx_m;
    logic [BHT_DEPTH-1:0] bidx_f, bidx_m;
    logic [BHR_WIDTH-1:0] bhr_f;
    logic [CTR_WIDTH-1:0] g_ctr_f, l_ctr_f, c_ctr_f;
    logic [CTR_WIDTH-1:0] g_cur_m, l_cur_m, c_cur_m;

    logic [GHR_WIDTH-1:0] ghr_snap;
    logic [BHR_WIDTH-1:0] bhr_snap;
    logic                 pg_m, pl_m, pred_m, mis_m;
    logic                 g_ok, l_ok, ch_we;
    logic                 unused_bits;

    // F-side indexing from the live GHR and BHT.
    always_comb begin
        bidx_f = pcF[BHT_DEPTH+1:2];
        bhr_f  = bht_q[bidx_f];
        gidx_f = pcF[PHT_DEPTH+1:2] ^ PHT_DEPTH'(ghr_q);
        lidx_f = {bidx_f, bhr_f};
    end

    // M-side indexing rebuilt from pcM and the carried snapshots.
    always_comb begin
        ghr_snap = metaM[GHR_OFF +: GHR_WIDTH];
        bhr_snap = metaM[META_BHR_OFF +: BHR_WIDTH];
        pg_m     = metaM[META_PG_OFF];
        pl_m     = metaM[META_PL_OFF];
        bidx_m   = pcM[BHT_DEPTH+1:2];
        gidx_m   = pcM[PHT_DEPTH+1:2] ^ PHT_DEPTH'(ghr_snap);
        lidx_m   = {bidx_m, bhr_snap};
        pred_m   = c_cur_m[MSB] ? pl_m : pg_m;
        mis_m    = branchM & (actualM != pred_m);
        g_ok     = (pg_m == actualM);
        l_ok     = (pl_m == actualM);
        ch_we    = branchM & (g_ok != l_ok);
    end

    always_comb begin
        takenF   = ~rst & (c_ctr_f[MSB] ? l_ctr_f[MSB] : g_ctr_f[MSB]);
        metaF    = {ghr_q, bhr_f, g_ctr_f[MSB], l_ctr_f[MSB]};
        mispredM = ~rst & mis_m;
    end

    bp_sat_table #(.DEPTH(PHT_DEPTH), .CTR_WIDTH(CTR_WIDTH)) u_gpht (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (gidx_f),
        .rd_ctr (g_ctr_f),
        .we     (branchM),
        .wr_idx (gidx_m),
        .wr_up  (actualM),
        .wr_cur (g_cur_m)
    );

    bp_sat_table #(.DEPTH(PHT_DEPTH), .CTR_WIDTH(CTR_WIDTH)) u_lpht (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (lidx_f),
        .rd_ctr (l_ctr_f),
        .we     (branchM),
        .wr_idx (lidx_m),
        .wr_up  (actualM),
        .wr_cur (l_cur_m)
    );

    // Chooser moves toward whichever component alone was right.
    bp_sat_table #(.DEPTH(PHT_DEPTH), .CTR_WIDTH(CTR_WIDTH)) u_chooser (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (gidx_f),
        .rd_ctr (c_ctr_f),
        .we     (ch_we),
        .wr_idx (gidx_m),
        .wr_up  (l_ok),
        .wr_cur (c_cur_m)
    );

    // Recovery beats the D shift: the D instruction is on the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (mis_m) begin
            ghr_d = GHR_WIDTH'({ghr_snap, actualM});
        end else if (branchD & ~stall) begin
            ghr_d = GHR_WIDTH'({ghr_q, takenD});
        end
        bht_d = BHR_WIDTH'({bhr_snap, actualM});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
            for (int i = 0; i < int'(BHT_N); i++) begin
                bht_q[i] <= '0;
            end
        end else begin
            ghr_q <= ghr_d;
            if (branchM) begin
                bht_q[bidx_m] <= bht_d;
            end
        end
    end

    assign unused_bits = ^{pcF[31:PHT_DEPTH+2], pcF[1:0], pcM[31:PHT_DEPTH+2],
                           pcM[1:0], g_cur_m, l_cur_m};

endmodule

// File: tb/tb_bp_tournament.sv
// Directed vector bench for bp_tournament at default parameters.
module tb_bp_tournament;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic        takenF;
    logic [9:0]  metaF;
    logic        branchD = 1'b0;
    logic        takenD = 1'b0;
    logic        stall = 1'b0;
    logic        branchM = 1'b0;
    logic        actualM = 1'b0;
    logic [31:0] pcM = '0;
    logic [9:0]  metaM = '0;
    logic        mispredM;

    int n_checks = 0;
    int n_err    = 0;

    bp_tournament dut (
        .clk      (clk),
        .rst      (rst),
        .pcF      (pcF),
        .takenF   (takenF),
        .metaF    (metaF),
        .branchD  (branchD),
        .takenD   (takenD),
        .stall    (stall),
        .branchM  (branchM),
        .actualM  (actualM),
        .pcM      (pcM),
        .metaM    (metaM),
        .mispredM (mispredM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc_f;
        logic        br_d;
        logic        tk_d;
        logic        stall;
        logic        br_m;
        logic        act_m;
        logic [31:0] pc_m;
        logic [9:0]  meta_m;
        logic        e_taken;
        logic [9:0]  e_meta;
        logic        e_mis;
        logic [3:0]  e_ghr;
        logic [1:0]  e_g10;
        logic [1:0]  e_c10;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic r, input logic [31:0] pf, input logic bd, input logic td,
        input logic st, input logic bm, input logic am, input logic [31:0] pm,
        input logic [9:0] mm, input logic et, input logic [9:0] em, input logic emis,
        input logic [3:0] eg, input logic [1:0] g10, input logic [1:0] c10);
        vec_t v;
        v.rst = r;   v.pc_f = pf;  v.br_d = bd;  v.tk_d = td;  v.stall = st;
        v.br_m = bm; v.act_m = am; v.pc_m = pm;  v.meta_m = mm;
        v.e_taken = et; v.e_meta = em; v.e_mis = emis;
        v.e_ghr = eg;   v.e_g10 = g10; v.e_c10 = c10;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive mid-cycle, check combinational outputs, then state after the edge.
    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        @(negedge clk);
        rst = v.rst;     pcF = v.pc_f;     branchD = v.br_d; takenD = v.tk_d;
        stall = v.stall; branchM = v.br_m; actualM = v.act_m;
        pcM = v.pc_m;    metaM = v.meta_m;
        #1;
        chk($sformatf("row%0d takenF", i),   32'(takenF),   32'(v.e_taken));
        chk($sformatf("row%0d metaF", i),    32'(metaF),    32'(v.e_meta));
        chk($sformatf("row%0d mispredM", i), 32'(mispredM), 32'(v.e_mis));
        @(posedge clk);
        #1;
        chk($sformatf("row%0d ghr", i),        32'(dut.ghr_q),               32'(v.e_ghr));
        chk($sformatf("row%0d gpht[10]", i),   32'(dut.u_gpht.ctr_q[16]),    32'(v.e_g10));
        chk($sformatf("row%0d chooser[10]", i), 32'(dut.u_chooser.ctr_q[16]), 32'(v.e_c10));
    endtask

    initial begin
        // reset, then saturate GPHT[0x10] with mispredicted taken branches
        tbl[0]  = mk(1, 'h40, 0,0,0, 0,0, 'h00, 'h000,  0, 'h000, 0,  4'h0, 2'd1, 2'd1);
        tbl[1]  = mk(0, 'h40, 0,0,0, 0,0, 'h00, 'h000,  0, 'h000, 0,  4'h0, 2'd1, 2'd1);
        tbl[2]  = mk(0, 'h40, 0,0,0, 1,1, 'h40, 'h000,  0, 'h000, 1,  4'h1, 2'd2, 2'd1);
        tbl[3]  = mk(0, 'h40, 0,0,0, 1,1, 'h40, 'h000,  0, 'h044, 1,  4'h1, 2'd3, 2'd1);
        tbl[4]  = mk(0, 'h40, 0,0,0, 1,1, 'h40, 'h000,  0, 'h044, 1,  4'h1, 2'd3, 2'd1);
        tbl[5]  = mk(0, 'h44, 0,0,0, 0,0, 'h00, 'h000,  1, 'h042, 0,  4'h1, 2'd3, 2'd1);
        // speculative shifts, then recovery winning over a same-cycle D shift
        tbl[6]  = mk(1, 'h40, 0,0,0, 0,0, 'h00, 'h000,  0, 'h000, 0,  4'h0, 2'd1, 2'd1);
        tbl[7]  = mk(0, 'h40, 1,1,0, 0,0, 'h00, 'h000,  0, 'h000, 0,  4'h1, 2'd1, 2'd1);
        tbl[8]  = mk(0, 'h40, 1,1,0, 0,0, 'h00, 'h000,  0, 'h040, 0,  4'h3, 2'd1, 2'd1);
        tbl[9]  = mk(0, 'h40, 1,1,0, 0,0, 'h00, 'h000,  0, 'h0C0, 0,  4'h7, 2'd1, 2'd1);
        tbl[10] = mk(0, 'h40, 1,1,0, 1,0, 'h40, 'h083,  0, 'h1C0, 1,  4'h4, 2'd1, 2'd1);
        // stalled D branches leave the GHR alone
        tbl[11] = mk(0, 'h40, 1,1,1, 0,0, 'h00, 'h000,  0, 'h100, 0,  4'h4, 2'd1, 2'd1);
        tbl[12] = mk(0, 'h40, 1,1,1, 0,0, 'h00, 'h000,  0, 'h100, 0,  4'h4, 2'd1, 2'd1);
        tbl[13] = mk(0, 'h40, 1,1,1, 0,0, 'h00, 'h000,  0, 'h100, 0,  4'h4, 2'd1, 2'd1);
        tbl[14] = mk(0, 'h40, 1,1,1, 0,0, 'h00, 'h000,  0, 'h100, 0,  4'h4, 2'd1, 2'd1);
        // chooser drifts to local, then a trained local entry drives takenF
        tbl[15] = mk(1, 'h40, 0,0,0, 0,0, 'h00, 'h000,  0, 'h000, 0,  4'h0, 2'd1, 2'd1);
        tbl[16] = mk(0, 'h40, 0,0,0, 1,0, 'h40, 'h002,  0, 'h000, 1,  4'h0, 2'd0, 2'd2);
        tbl[17] = mk(0, 'h40, 0,0,0, 1,0, 'h40, 'h002,  0, 'h000, 0,  4'h0, 2'd0, 2'd3);
        tbl[18] = mk(0, 'h40, 0,0,0, 1,1, 'h40, 'h03D,  0, 'h000, 0,  4'h0, 2'd1, 2'd3);
        tbl[19] = mk(0, 'h40, 0,0,0, 0,0, 'h00, 'h000,  1, 'h03D, 0,  4'h0, 2'd1, 2'd3);

        for (int i = 0; i < 20; i++) begin
            run_vec(i);
        end

        // Replay the saturation sequence, then hit rst between edges.
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end
        chk("pre-async takenF", 32'(takenF), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async takenF",   32'(takenF),               32'd0);
        chk("async metaF",    32'(metaF),                32'd0);
        chk("async ghr",      32'(dut.ghr_q),            32'd0);
        chk("async gpht[10]", 32'(dut.u_gpht.ctr_q[16]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset takenF", 32'(takenF), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
